// File: rtl/extio8x4_pkg.sv
// Shared constants and helpers for the extio8x4 input synchroniser.
// Holds the legal parameter ranges and the filter counter width function.
package extio8x4_pkg;

  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 32;
  localparam int STAGES_MIN   = 2;
  localparam int STAGES_MAX   = 4;
  localparam int FILTER_MIN   = 1;
  localparam int FILTER_MAX   = 15;

  // Width of a counter that holds 0..filter_cycles (never narrower than 1 bit).
  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/extio8x4_sync_chain.sv
// Single-channel synchroniser: STAGES-deep flop chain for one async input.
// Exposes the chain output and the value it will take on the next edge, so
// the parent can register edge pulses aligned with the output change.
module extio8x4_sync_chain
  import extio8x4_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic sync_o,
  output logic sync_next_o
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("extio8x4_sync_chain: STAGES out of range");
  end

  logic [STAGES-1:0] chain_q;

  // Shift the async input through the chain; stage 0 is the metastable one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain_q <= {STAGES{RESET_VALUE}};
    end else begin
      // NOTE: non-blocking so every stage samples the pre-edge value of its
      // predecessor; blocking here would collapse the chain to one flop.
      chain_q <= {chain_q[STAGES-2:0], sig_i};
    end
  end

  assign sync_o      = chain_q[STAGES-1];
  assign sync_next_o = chain_q[STAGES-2];

endmodule

// File: rtl/extio8x4_syncn.sv
// extio8x4_syncn: multi-channel async input synchroniser with optional glitch
// filter and registered rise/fall pulses.
// Build option: define EXTIO8X4_SYNCN_FILTER_EN to compile in the per-channel
// glitch filter; without it sig_s is the raw synchroniser output.
module extio8x4_syncn
  import extio8x4_pkg::*;
#(
  parameter int                  CHANNELS      = 8,
  parameter int                  STAGES        = 2,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}},
  parameter int                  FILTER_CYCLES = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                testmode,
  input  logic [CHANNELS-1:0] sig_a,
  output logic [CHANNELS-1:0] sig_s,
  output logic [CHANNELS-1:0] sig_rise,
  output logic [CHANNELS-1:0] sig_fall
);

  // Reject illegal configurations at elaboration. FILTER_CYCLES is range
  // checked in both builds so a parameter set stays valid either way.
  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("extio8x4_syncn: CHANNELS out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("extio8x4_syncn: STAGES out of range");
  end
  if (FILTER_CYCLES < FILTER_MIN || FILTER_CYCLES > FILTER_MAX) begin : g_bad_filter
    $error("extio8x4_syncn: FILTER_CYCLES out of range");
  end

  logic [CHANNELS-1:0] sync_q;   // synchroniser outputs
  logic [CHANNELS-1:0] sync_d;   // synchroniser outputs after the next edge
  logic [CHANNELS-1:0] level_q;  // functional level presented on sig_s
  logic [CHANNELS-1:0] level_d;  // level_q after the next edge
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chain
    extio8x4_sync_chain #(
      .STAGES      (STAGES),
      .RESET_VALUE (RESET_VALUE[gi])
    ) u_chain (
      .clk         (clk),
      .resetn      (resetn),
      .sig_i       (sig_a[gi]),
      .sync_o      (sync_q[gi]),
      .sync_next_o (sync_d[gi])
    );
  end

`ifdef EXTIO8X4_SYNCN_FILTER_EN
  localparam int               CNT_W   = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [CHANNELS-1:0] filt_q;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // The look-ahead chain value only feeds the unfiltered edge path.
  logic unused_sync_d;
  assign unused_sync_d = ^sync_d;

  // Filter rule: a disagreeing level must persist FILTER_CYCLES cycles before
  // it is accepted; any agreement clears the count, so it never wraps.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise the
    // tool infers latches for the untouched branches.
    level_d = filt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter state; reset drops any partial count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q <= RESET_VALUE;
      // NOTE: the counter array is control state, not storage, so every entry
      // is reset; a stale count would shorten the first filter window.
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= level_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_q = filt_q;
`else
  assign level_q = sync_q;
  assign level_d = sync_d;
`endif

  // Register edge pulses from the upcoming level change so they coincide with
  // the cycle in which the new level first appears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  // Test bypass: raw inputs straight through, pulses suppressed, state keeps
  // clocking so leaving testmode causes no spurious edges.
  assign sig_s    = testmode ? sig_a : level_q;
  assign sig_rise = rise_q & {CHANNELS{~testmode}};
  assign sig_fall = fall_q & {CHANNELS{~testmode}};

endmodule
